inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset; word-aligned.
REQ-002 Parameter: DEPTH, 2, instruction buffer entries; fixed at 2 for this revision.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rstN  input  1  reset, synchronous, active-low.
REQ-005 Port: fetchEn  input  1  level enable; 1 = fetch, 0 = stop issuing reads.
REQ-006 Port: redirectValid  input  1  one-cycle branch/jump redirect strobe.
REQ-007 Port: redirectTarget  input  32  redirect byte address.
REQ-008 Port: instRead  output  1  read strobe to instruction memory.
REQ-009 Port: instAddress  output  32  byte address to instruction memory.
REQ-010 Port: instData  input  32  instruction word, valid combinationally in the same cycle as instRead.
REQ-011 Port: outValid  output  1  buffer head holds a valid instruction for decode.
REQ-012 Port: outReady  input  1  decode accepts the head this cycle.
REQ-013 Port: outInst  output  32  head instruction word.
REQ-014 Port: outPc  output  32  byte address of the head instruction.
REQ-015 Port: bufCount  output  2  current buffer occupancy, 0..2.

Function
REQ-016 FSM states: IDLE, RUN; IDLE->RUN when fetchEn=1; RUN->IDLE when fetchEn=0; transitions take effect next edge.
REQ-017 instAddress SHALL equal the PC register at all times.
REQ-018 instRead=1 only when state=RUN, redirectValid=0, and (bufCount<2 or (bufCount=2 and outReady=1)).
REQ-019 Every cycle with instRead=1 SHALL enqueue {instAddress, instData} at the next edge and set PC<=PC+4.
REQ-020 PC increment wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-021 Dequeue occurs on an edge where outValid=1 and outReady=1; outReady with outValid=0 has no effect.
REQ-022 Simultaneous enqueue and dequeue SHALL leave bufCount unchanged and preserve FIFO order.
REQ-023 Buffer full (bufCount=2) with outReady=0: instRead=0, PC held.
REQ-024 outValid = (bufCount!=0); outInst/outPc driven from head entry; contents undefined and ignored when outValid=0.
REQ-025 redirectValid=1 (any state): next edge PC<=redirectTarget with bits [1:0] forced to 0, buffer flushed (bufCount<=0), no enqueue that cycle.
REQ-026 Redirect has priority over enqueue and dequeue in the same cycle; a head accepted by decode in that cycle counts as consumed, then flush applies.
REQ-027 Redirect in IDLE updates PC and flushes; state stays IDLE.
REQ-028 fetchEn=0 stops new reads only; buffered entries remain and drain normally.
REQ-029 Fetch-to-outValid latency: 1 cycle (read in cycle N, outValid=1 in N+1 if buffer was empty).

Reset
REQ-030 When rstN=0 at a rising edge: state<=IDLE, PC<=RESET_PC, bufCount<=0; overrides redirect and all handshakes.
REQ-031 Outputs after reset: instRead=0, instAddress=RESET_PC, outValid=0, bufCount=0.
REQ-032 Reset asserted mid-operation discards all buffered entries; no partial entry survives.

Structure
REQ-033 Shared package inst_fetch_pkg SHALL hold the state enum (IDLE, RUN), the word-size constant (4), and the default RESET_PC.
REQ-034 Buffer SHALL be the sub-module fetch_fifo (2-entry, 64-bit entry {pc, inst}, push/pop/flush, count); FSM and PC stay in inst_fetch.

Verification
REQ-035 Reset then fetchEn=1, outReady=1, memory word[i]=i: addresses 0,4,8 issued on consecutive cycles; outPc 0,4,8 with outInst 0,1,2, one cycle later each.
REQ-036 outReady=0 for 5 cycles in RUN: bufCount reaches 2, instRead=0, PC frozen at 8; outReady=1 resumes with no lost or duplicated pc.
REQ-037 redirectValid=1, redirectTarget=32'h0000_0043 while bufCount=2: next cycle bufCount=0, instAddress=32'h0000_0040, following outPc=32'h0000_0040.
REQ-038 RESET_PC=32'hFFFF_FFF8, free run: outPc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 rstN=0 for one cycle while bufCount=1 and outReady=0: next cycle outValid=0, state IDLE, instAddress=RESET_PC.
REQ-040 fetchEn dropped with bufCount=2, outReady=1: two entries drain in order, then outValid=0, instRead stays 0.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package inst_fetch_pkg;

    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Sequential fetch address; wraps naturally modulo 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'(WORD_BYTES);
    endfunction

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer holding {pc, inst} entries between fetch and decode.
// Flush wins over push and pop in the same cycle.
module fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int COUNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               i_push,
    input  fetch_entry_t       i_push_data,
    input  logic               i_pop,
    input  logic               i_flush,
    output fetch_entry_t       o_head,
    output logic [COUNT_W-1:0] o_count,
    output logic               o_empty,
    output logic               o_full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [COUNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == COUNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (w_do_push && (r_wr_ptr == PTR_W'(gi))) begin
                    r_mem[gi] <= i_push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstN || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + COUNT_W'(1);
                2'b01:   r_count <= r_count - COUNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC sequencing, IDLE/RUN control and redirect handling,
// feeding a 2-entry buffer that decode drains with a valid/ready handshake.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        fetchEn,
    input  logic        redirectValid,
    input  logic [31:0] redirectTarget,
    output logic        instRead,
    output logic [31:0] instAddress,
    input  logic [31:0] instData,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] outInst,
    output logic [31:0] outPc,
    output logic [1:0]  bufCount
);

    state_e       r_state;
    state_e       w_state_next;
    logic [31:0]  r_pc;
    logic         w_fetch;
    logic [1:0]   w_count;
    logic         w_full;
    logic         w_empty;
    fetch_entry_t w_head;
    fetch_entry_t w_push_data;
    logic         w_unused_target_bits;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (fetchEn)  w_state_next = RUN;
            RUN:     if (!fetchEn) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Reading is allowed into a full buffer only when its head is leaving now.
    always_comb begin
        w_fetch = 1'b0;
        if (r_state == RUN && !redirectValid) begin
            w_fetch = !w_full || outReady;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_pc <= RESET_PC;
        end else if (redirectValid) begin
            r_pc <= align_word(redirectTarget);
        end else if (w_fetch) begin
            r_pc <= next_pc(r_pc);
        end
    end

    assign w_push_data = '{pc: r_pc, inst: instData};

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .COUNT_W (2)
    ) u_fifo (
        .clk         (clk),
        .rstN        (rstN),
        .i_push      (w_fetch),
        .i_push_data (w_push_data),
        .i_pop       (outReady),
        .i_flush     (redirectValid),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_empty     (w_empty),
        .o_full      (w_full)
    );

    assign w_unused_target_bits = &{1'b0, redirectTarget[1:0]};

    assign instRead    = w_fetch;
    assign instAddress = r_pc;
    assign outValid    = !w_empty;
    assign outInst     = w_head.inst;
    assign outPc       = w_head.pc;
    assign bufCount    = w_count;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table, wrap-around run, and a
// randomized run checked against a queue-based reference model.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN, fetchEn, redirectValid, outReady;
    logic [31:0] redirectTarget;

    logic        instRead0, outValid0, instRead1, outValid1;
    logic [31:0] instAddress0, instData0, outInst0, outPc0;
    logic [31:0] instAddress1, instData1, outInst1, outPc1;
    logic [1:0]  bufCount0, bufCount1;

    // Memory image: word[i] = i.
    assign instData0 = {2'b00, instAddress0[31:2]};
    assign instData1 = {2'b00, instAddress1[31:2]};

    inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut0 (
        .clk(clk), .rstN(rstN), .fetchEn(fetchEn), .redirectValid(redirectValid),
        .redirectTarget(redirectTarget), .instRead(instRead0), .instAddress(instAddress0),
        .instData(instData0), .outValid(outValid0), .outReady(outReady),
        .outInst(outInst0), .outPc(outPc0), .bufCount(bufCount0));

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut1 (
        .clk(clk), .rstN(rstN), .fetchEn(fetchEn), .redirectValid(redirectValid),
        .redirectTarget(redirectTarget), .instRead(instRead1), .instAddress(instAddress1),
        .instData(instData1), .outValid(outValid1), .outReady(outReady),
        .outInst(outInst1), .outPc(outPc1), .bufCount(bufCount1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic fe, input logic ordy,
                         input logic rv, input logic [31:0] rt);
        @(negedge clk);
        rstN = rst_n; fetchEn = fe; outReady = ordy;
        redirectValid = rv; redirectTarget = rt;
        #1;
    endtask

    typedef struct {
        logic        rst_n, fe, ordy, rv;
        logic [31:0] rt;
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc, e_inst;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t tbl[23];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ref_ent_t;

    ref_ent_t    q[$];
    logic        m_run;
    logic [31:0] m_pc;

    initial begin
        logic [31:0] wrap_pc[3];
        int          got;

        rstN = 1'b0; fetchEn = 1'b0; outReady = 1'b0;
        redirectValid = 1'b0; redirectTarget = 32'h0;

        //         rst   fe    rdy   rv    rt            read  addr          vld   pc            inst          cnt
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        2'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        32'h0,        2'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        1'b1, 32'h0,        32'h0,        2'd1};
        for (int i = 3; i <= 6; i++)
            tbl[i] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 32'h8,        1'b1, 32'h0,        32'h0,        2'd2};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'h0,        32'h0,        2'd2};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 32'h4,        32'h1,        2'd2};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h10,       1'b1, 32'h8,        32'h2,        2'd2};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h43,       1'b0, 32'h14,       1'b1, 32'hC,        32'h3,        2'd2};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h40,       1'b0, 32'h0,        32'h0,        2'd0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h44,       1'b1, 32'h40,       32'h10,       2'd1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h48,       1'b1, 32'h40,       32'h10,       2'd2};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h48,       1'b1, 32'h40,       32'h10,       2'd2};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h48,       1'b1, 32'h44,       32'h11,       2'd1};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h48,       1'b0, 32'h0,        32'h0,        2'd0};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h48,       1'b0, 32'h0,        32'h0,        2'd0};
        tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h48,       1'b0, 32'h0,        32'h0,        2'd0};
        tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h4C,       1'b1, 32'h48,       32'h12,       2'd1};
        tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        2'd0};
        tbl[21] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h107,      1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        2'd0};
        tbl[22] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h104,      1'b0, 32'h0,        32'h0,        2'd0};

        // Directed table
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].rst_n, tbl[i].fe, tbl[i].ordy, tbl[i].rv, tbl[i].rt);
            chk($sformatf("vec%0d instRead", i),    32'(instRead0),   32'(tbl[i].e_read));
            chk($sformatf("vec%0d instAddress", i), instAddress0,     tbl[i].e_addr);
            chk($sformatf("vec%0d outValid", i),    32'(outValid0),   32'(tbl[i].e_valid));
            chk($sformatf("vec%0d bufCount", i),    32'(bufCount0),   32'(tbl[i].e_cnt));
            if (tbl[i].e_valid) begin
                chk($sformatf("vec%0d outPc", i),   outPc0,   tbl[i].e_pc);
                chk($sformatf("vec%0d outInst", i), outInst0, tbl[i].e_inst);
            end
            $display("vec%0d addr=%h read=%b valid=%b pc=%h inst=%h cnt=%0d",
                     i, instAddress0, instRead0, outValid0, outPc0, outInst0, bufCount0);
        end

        // PC wrap-around from a high reset address
        wrap_pc[0] = 32'hFFFF_FFF8; wrap_pc[1] = 32'hFFFF_FFFC; wrap_pc[2] = 32'h0000_0000;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap reset addr", instAddress1, 32'hFFFF_FFF8);
        got = 0;
        for (int c = 0; c < 12 && got < 3; c++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            if (outValid1) begin
                chk($sformatf("wrap outPc%0d", got), outPc1, wrap_pc[got]);
                chk($sformatf("wrap outInst%0d", got), outInst1, {2'b00, wrap_pc[got][31:2]});
                $display("wrap%0d pc=%h inst=%h", got, outPc1, outInst1);
                got++;
            end
        end
        chk("wrap entries seen", 32'(got), 32'd3);

        // Randomized run against reference model
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        m_run = 1'b0; m_pc = 32'h0; q.delete();
        for (int c = 0; c < 3000; c++) begin
            logic        rst_n, fe, ordy, rv, e_read;
            logic [31:0] rt;
            rst_n = ($urandom_range(0, 199) != 0);
            fe    = ($urandom_range(0, 9) < 8);
            ordy  = ($urandom_range(0, 2) != 0);
            rv    = ($urandom_range(0, 19) == 0);
            rt    = $urandom;
            drive(rst_n, fe, ordy, rv, rt);

            e_read = m_run && !rv && (q.size() < 2 || ordy);
            chk("rnd instRead",    32'(instRead0), 32'(e_read));
            chk("rnd instAddress", instAddress0,   m_pc);
            chk("rnd outValid",    32'(outValid0), 32'(q.size() != 0));
            chk("rnd bufCount",    32'(bufCount0), 32'(q.size()));
            if (q.size() != 0) begin
                chk("rnd outPc",   outPc0,   q[0].pc);
                chk("rnd outInst", outInst0, q[0].inst);
            end

            if (!rst_n) begin
                m_run = 1'b0; m_pc = 32'h0; q.delete();
            end else begin
                if (rv) begin
                    m_pc = {rt[31:2], 2'b00};
                    q.delete();
                end else begin
                    if (q.size() != 0 && ordy) void'(q.pop_front());
                    if (e_read) begin
                        q.push_back('{pc: m_pc, inst: m_pc >> 2});
                        m_pc = m_pc + 32'd4;
                    end
                end
                m_run = fe;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
